mod12_down: RTL and testbench

//  Loadable two-digit BCD down-counter, modulo 12: counts 11,10,09..00, then wraps to 11.
//  It is the count-down counterpart of the timer's mod-12 up-counter stage.
//  It is driven by an upstream enable/borrow chain and feeds its borrow (tc) to the next stage.
//  It is used for countdown / set-time modes of the timer.

---
 rtl/mod12_pkg.sv | 14 +
 rtl/mod12_down_if.sv | 22 ++
 rtl/bcd_down_digit.sv | 35 +++
 rtl/mod12_down.sv | 104 ++++++++++
 tb/tb_mod12_down.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/mod12_pkg.sv
// Shared constants and BCD legality helper for the mod-12 timer stages.
package mod12_pkg;

    localparam logic [4:0] MOD12_MAXV    = 5'h11;
    localparam logic [3:0] BCD_UNITS_MAX = 4'd9;

    function automatic logic bcd12_legal(input logic [4:0] v);
        if (v[4]) begin
            return v[3:0] <= 4'd1;
        end
        return v[3:0] <= BCD_UNITS_MAX;
    endfunction

endpackage

// File: rtl/mod12_down_if.sv
// Control/status bundle between a timer controller and a mod-12 down stage.
interface mod12_down_if;

    logic       en;
    logic       load;
    logic [4:0] load_val;
    logic       tc;
    logic       zero;
    logic       load_err;
    logic [4:0] cnt_num;

    modport master (
        output en, load, load_val,
        input  tc, zero, load_err, cnt_num
    );

    modport slave (
        input  en, load, load_val,
        output tc, zero, load_err, cnt_num
    );

endinterface

// File: rtl/bcd_down_digit.sv
// Single modulo-M down-counting digit; borrow-out when enabled at zero.
module bcd_down_digit #(
    parameter int unsigned N   = 4,
    parameter int unsigned M   = 10,
    parameter logic [N-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] ld_val,
    output logic         bw,
    output logic [N-1:0] cnt
);

    logic [N-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST;
        end else if (load) begin
            cnt_q <= ld_val;
        end else if (en) begin
            if (cnt_q == '0) begin
                cnt_q <= N'(M - 1);
            end else begin
                cnt_q <= cnt_q - N'(1);
            end
        end
    end

    assign bw  = en & (cnt_q == '0);
    assign cnt = cnt_q;

endmodule

// File: rtl/mod12_down.sv
// BCD modulo-12 down-counter stage (11..00).
// Define MOD12_DOWN_SAT_EN to saturate at 00 instead of wrapping.
module mod12_down
    import mod12_pkg::*;
#(
    parameter logic [4:0] MAXV = MOD12_MAXV,
    parameter logic [4:0] RSTV = MOD12_MAXV
) (
    input  logic clk,
    input  logic rst_n,
    mod12_down_if.slave bus
);

`ifdef MOD12_DOWN_SAT_EN
    localparam logic [4:0] WRAPV = 5'h00;
`else
    localparam logic [4:0] WRAPV = MAXV;
`endif

    logic [3:0] units;
    logic       tens;
    logic [4:0] cnt;
    logic       u_bw;
    logic       t_bw;
    logic       legal;
    logic       wrap;
    logic       dig_ld;
    logic [4:0] ld_val;
    logic [4:0] cnt_d;
    logic       zero_q;
    logic       err_q;

    assign cnt   = {tens, units};
    assign legal = bcd12_legal(bus.load_val);
    assign wrap  = bus.en & ~bus.load & (cnt == 5'h00);

    // Both digits are force-loaded on wrap so 00 never decays to 19.
    assign dig_ld = bus.load | wrap;

    always_comb begin
        ld_val = WRAPV;
        if (bus.load) begin
            ld_val = legal ? bus.load_val : MAXV;
        end
    end

    bcd_down_digit #(
        .N   (4),
        .M   (10),
        .RST (RSTV[3:0])
    ) u_units (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (bus.en),
        .load   (dig_ld),
        .ld_val (ld_val[3:0]),
        .bw     (u_bw),
        .cnt    (units)
    );

    bcd_down_digit #(
        .N   (1),
        .M   (2),
        .RST (RSTV[4])
    ) u_tens (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (u_bw),
        .load   (dig_ld),
        .ld_val (ld_val[4]),
        .bw     (t_bw),
        .cnt    (tens)
    );

    always_comb begin
        cnt_d = cnt;
        if (dig_ld) begin
            cnt_d = ld_val;
        end else if (bus.en) begin
            if (units == 4'd0) begin
                cnt_d = {1'b0, BCD_UNITS_MAX};
            end else begin
                cnt_d = {tens, units - 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            zero_q <= (cnt_d == 5'h00);
            err_q  <= bus.load & ~legal;
        end
    end

    // Chained borrow equals en & (count == 00).
    assign bus.tc       = t_bw;
    assign bus.zero     = zero_q;
    assign bus.load_err = err_q;
    assign bus.cnt_num  = cnt;

endmodule

// File: tb/tb_mod12_down.sv
// Scoreboard bench for mod12_down: driver queues expectations,
// monitor compares after each clock edge.
module tb_mod12_down;

    typedef struct {
        logic       tc;
        logic [4:0] cnt;
        logic       zero;
        logic       err;
        string      name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    logic tc_s;

    mod12_down_if bus ();

    mod12_down dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // tc is sampled while the inputs of the cycle are stable.
    always @(negedge clk) begin
        #2 tc_s = bus.tc;
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, ".tc"}, int'(tc_s), int'(e.tc));
            chk({e.name, ".cnt"}, int'(bus.cnt_num), int'(e.cnt));
            chk({e.name, ".zero"}, int'(bus.zero), int'(e.zero));
            chk({e.name, ".err"}, int'(bus.load_err), int'(e.err));
        end
    end

    task automatic step(input logic en, input logic ld,
                        input logic [4:0] val, input logic etc,
                        input logic [4:0] ecnt, input logic eerr,
                        input string nm);
        exp_t e;
        @(negedge clk);
        bus.en       = en;
        bus.load     = ld;
        bus.load_val = val;
        e.tc   = etc;
        e.cnt  = ecnt;
        e.zero = (ecnt == 5'h00);
        e.err  = eerr;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < 5) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d items left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    logic [4:0] seq [13];

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        tc_s         = 1'b0;
        bus.en       = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = 5'h00;
        rst_n        = 1'b0;
        #12;
        chk("rst.cnt", int'(bus.cnt_num), 'h11);
        chk("rst.zero", int'(bus.zero), 0);
        chk("rst.err", int'(bus.load_err), 0);
        chk("rst.tc", int'(bus.tc), 0);
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        seq = '{5'h11, 5'h10, 5'h09, 5'h08, 5'h07, 5'h06, 5'h05,
                5'h04, 5'h03, 5'h02, 5'h01, 5'h00, 5'h11};
`ifdef MOD12_DOWN_SAT_EN
        seq[12] = 5'h00;
`endif
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 5'h00, seq[i] == 5'h00,
                 seq[i + 1], 1'b0, $sformatf("cnt%0d", i));
        end

        step(1'b0, 1'b1, 5'h07, 1'b0, 5'h07, 1'b0, "ld07");
        step(1'b0, 1'b0, 5'h00, 1'b0, 5'h07, 1'b0, "hold1");
        step(1'b0, 1'b0, 5'h00, 1'b0, 5'h07, 1'b0, "hold2");

        step(1'b0, 1'b1, 5'h1A, 1'b0, 5'h11, 1'b1, "ld1A");
        step(1'b0, 1'b0, 5'h00, 1'b0, 5'h11, 1'b0, "ld1A_end");
        step(1'b0, 1'b1, 5'h12, 1'b0, 5'h11, 1'b1, "ld12");
        step(1'b0, 1'b0, 5'h00, 1'b0, 5'h11, 1'b0, "ld12_end");
        step(1'b0, 1'b1, 5'h0A, 1'b0, 5'h11, 1'b1, "ld0A");
        step(1'b0, 1'b1, 5'h10, 1'b0, 5'h10, 1'b0, "ld10");
        step(1'b1, 1'b0, 5'h00, 1'b0, 5'h09, 1'b0, "10to09");

        step(1'b0, 1'b1, 5'h00, 1'b0, 5'h00, 1'b0, "ld00");
        step(1'b1, 1'b1, 5'h05, 1'b1, 5'h05, 1'b0, "ldovr");
        step(1'b1, 1'b0, 5'h00, 1'b0, 5'h04, 1'b0, "to04");
        drain();

        @(negedge clk);
        bus.en   = 1'b0;
        bus.load = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst.cnt", int'(bus.cnt_num), 'h11);
        chk("arst.zero", int'(bus.zero), 0);
        chk("arst.err", int'(bus.load_err), 0);
        #0 rst_n = 1'b1;

        step(1'b0, 1'b1, 5'h01, 1'b0, 5'h01, 1'b0, "ld01");
        step(1'b1, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, "to00");
`ifdef MOD12_DOWN_SAT_EN
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 5'h00, 1'b1, 5'h00, 1'b0,
                 $sformatf("sat%0d", i));
        end
        step(1'b0, 1'b1, 5'h03, 1'b0, 5'h03, 1'b0, "ld03");
        step(1'b1, 1'b0, 5'h00, 1'b0, 5'h02, 1'b0, "resume");
`else
        step(1'b1, 1'b0, 5'h00, 1'b1, 5'h11, 1'b0, "wrap");
        step(1'b1, 1'b0, 5'h00, 1'b0, 5'h10, 1'b0, "after");
`endif
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
